// File: rtl/branch_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// branch_fwd_ctrl
// Hazard/forwarding controller for the decode-stage branch comparator.
// Tracks the destination registers of the instructions in S3/S4/S5 in a
// shadow pipeline and drives the comparator's S4/S5 forward selects. It
// stalls decode and injects S3 bubbles while a branch operand cannot be
// forwarded yet, and freezes while the data cache misses.
//
// Optional feature: define BRANCH_STALL_CNT_EN to add the stall_cnt port, a
// saturating count of bubble cycles (cleared only by reset).
//
// Ports
//   clk          clock, rising edge
//   rst_         async active-low reset
//   mem_stall    D-cache miss, whole pipe frozen this cycle
//   br_s2        S2 holds a beq/bne
//   rs1_s2       branch source 1
//   rs2_s2       branch source 2
//   rd_s2        S2 destination register
//   rd_we_s2     S2 instruction writes rd
//   load_s2      S2 instruction is a load
//   b_r1_fwd_s4  src1 <- alu_out_s4
//   b_r2_fwd_s4  src2 <- alu_out_s4
//   b_r1_fwd_s5  src1 <- reg_wdata
//   b_r2_fwd_s5  src2 <- reg_wdata
//   stall_s2     hold PC and S1/S2 registers
//   bubble_s3    load a NOP into S3
//   br_state     FSM state: 0 RUN, 1 HAZ, 2 FREEZE
//   stall_cnt    bubble-cycle counter (BRANCH_STALL_CNT_EN only)
//
// FSM states
//   state  | meaning
//   RUN    | no stall pending
//   HAZ    | a branch operand was not forwardable last cycle
//   FREEZE | pipe frozen by a data-cache miss last cycle
// ---------------------------------------------------------------------------
module branch_fwd_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  mem_stall,
    input  logic                  br_s2,
    input  logic [REG_ADDR_W-1:0] rs1_s2,
    input  logic [REG_ADDR_W-1:0] rs2_s2,
    input  logic [REG_ADDR_W-1:0] rd_s2,
    input  logic                  rd_we_s2,
    input  logic                  load_s2,
    output logic                  b_r1_fwd_s4,
    output logic                  b_r2_fwd_s4,
    output logic                  b_r1_fwd_s5,
    output logic                  b_r2_fwd_s5,
    output logic                  stall_s2,
    output logic                  bubble_s3,
    output logic [1:0]            br_state
`ifdef BRANCH_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HAZ    = 2'd1,
        ST_FREEZE = 2'd2
    } br_state_t;

    br_state_t state_q, state_d;

    logic [REG_ADDR_W-1:0] rd_s3_q, rd_s4_q, rd_s5_q;
    logic                  we_s3_q, we_s4_q, we_s5_q;
    logic                  ld_s3_q, ld_s4_q, ld_s5_q;

    logic m1_s3, m2_s3, m1_s4, m2_s4, m1_s5, m2_s5;
    logic hazard;

    // Register 0 is hardwired zero, so it never needs forwarding or stalling.
    assign m1_s3 = br_s2 & we_s3_q & (rd_s3_q == rs1_s2) & (rs1_s2 != '0);
    assign m2_s3 = br_s2 & we_s3_q & (rd_s3_q == rs2_s2) & (rs2_s2 != '0);
    assign m1_s4 = br_s2 & we_s4_q & (rd_s4_q == rs1_s2) & (rs1_s2 != '0);
    assign m2_s4 = br_s2 & we_s4_q & (rd_s4_q == rs2_s2) & (rs2_s2 != '0);
    assign m1_s5 = br_s2 & we_s5_q & (rd_s5_q == rs1_s2) & (rs1_s2 != '0);
    assign m2_s5 = br_s2 & we_s5_q & (rd_s5_q == rs2_s2) & (rs2_s2 != '0);

    // Load data is only available at S5, so a load in S4 still stalls.
    assign hazard = m1_s3 | m2_s3 | ((m1_s4 | m2_s4) & ld_s4_q);

    assign stall_s2  = hazard | mem_stall;
    assign bubble_s3 = hazard & ~mem_stall;

    // Selects are suppressed while the branch waits; S4 (younger) wins over S5.
    assign b_r1_fwd_s4 = ~hazard & m1_s4 & ~ld_s4_q;
    assign b_r2_fwd_s4 = ~hazard & m2_s4 & ~ld_s4_q;
    assign b_r1_fwd_s5 = ~hazard & m1_s5 & ~m1_s4;
    assign b_r2_fwd_s5 = ~hazard & m2_s5 & ~m2_s4;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rd_s3_q <= '0;
            rd_s4_q <= '0;
            rd_s5_q <= '0;
            we_s3_q <= 1'b0;
            we_s4_q <= 1'b0;
            we_s5_q <= 1'b0;
            ld_s3_q <= 1'b0;
            ld_s4_q <= 1'b0;
            ld_s5_q <= 1'b0;
        end else if (!mem_stall) begin
            rd_s5_q <= rd_s4_q;
            we_s5_q <= we_s4_q;
            ld_s5_q <= ld_s4_q;
            rd_s4_q <= rd_s3_q;
            we_s4_q <= we_s3_q;
            ld_s4_q <= ld_s3_q;
            rd_s3_q <= bubble_s3 ? '0 : rd_s2;
            we_s3_q <= bubble_s3 ? 1'b0 : rd_we_s2;
            ld_s3_q <= bubble_s3 ? 1'b0 : load_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall)   state_d = ST_FREEZE;
                else if (hazard) state_d = ST_HAZ;
            end
            ST_HAZ: begin
                if (mem_stall)    state_d = ST_FREEZE;
                else if (!hazard) state_d = ST_RUN;
            end
            ST_FREEZE: begin
                if (!mem_stall) state_d = hazard ? ST_HAZ : ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign br_state = state_q;

`ifdef BRANCH_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            stall_cnt <= '0;
        end else if (bubble_s3 && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule
